fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the pipelined datapath: owns the program counter, issues instruction reads to the instruction cache, and drives the fetch-side inputs of the fetch/decode pipeline latch (instruction, pc, pc+4, next pc, valid). Advances the PC on each instruction-cache hit unless stalled. Accepts taken-branch/jump redirects from later stages without breaking the cache's stable-address rule. Stops fetching permanently on halt until reset.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded at reset
- WORD_W, 32, address/instruction width (word_t)

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- nRST  input  1  reset, asynchronous, active-low
- stall  input  1  hazard-unit hold; PC must not advance
- redirect  input  1  taken branch/jump resolved this cycle (same signal also flushes the fetch/decode latch)
- redirect_pc  input  WORD_W  redirect target address
- halt  input  1  halt instruction committed downstream
- ihit  input  1  instruction cache: iload valid for iaddr this cycle
- iload  input  WORD_W  instruction cache read data
- iREN  output  1  instruction read enable
- iaddr  output  WORD_W  instruction read address
- fetch_instr_out  output  WORD_W  instruction to fetch/decode latch
- pc_out  output  WORD_W  address of fetch_instr_out
- pc4_out  output  WORD_W  pc_out + 4
- next_pc_out  output  WORD_W  value PC loads at next edge if it advances
- fetch_valid  output  1  fetch_instr_out is a live instruction this cycle
- halted  output  1  fetch stopped

## Operation
- Registers: pc (WORD_W), pend_pc (WORD_W), state in {RUN, DRAIN, HALTED}.
- Reset values: pc=PC_INIT, pend_pc=0, state=RUN. Outputs after reset: iREN=1, iaddr=PC_INIT, fetch_valid=ihit, halted=0, pc4_out=PC_INIT+4.
- Combinational outputs: iaddr=pc; pc_out=pc; pc4_out=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC→0); fetch_instr_out=iload; iREN=(state!=HALTED); halted=(state==HALTED).
- next_pc_out = redirect ? redirect_pc : pc4_out.
- fetch_valid = ihit && state==RUN && !redirect && !halt.
- Cache rule: while iREN=1, iaddr must not change until ihit. PC only changes on an edge where ihit=1.
- Transitions, priority halt > redirect > stall > advance:
  - Any state, halt=1: state→HALTED, pc holds.
  - RUN, redirect, ihit=1: pc←redirect_pc, stay RUN; fetched word discarded (fetch_valid=0).
  - RUN, redirect, ihit=0: pend_pc←redirect_pc, state→DRAIN, pc holds.
  - RUN, stall (no redirect), any ihit: pc holds.
  - RUN, ihit, no stall/redirect: pc←pc+4.
  - RUN, ihit=0: hold.
  - DRAIN, redirect: pend_pc←redirect_pc (newest wins); if also ihit: pc←redirect_pc, state→RUN.
  - DRAIN, ihit, no redirect: pc←pend_pc, state→RUN; fetched word discarded.
  - DRAIN, ihit=0: hold. Stall ignored in DRAIN.
  - HALTED: absorbing; only nRST exits. iREN=0, fetch_valid=0.
- redirect_pc is used as-is; no alignment check.

## Timing
- Zero-cycle combinational path ihit/iload → fetch_valid/fetch_instr_out; latch captures on the same edge the PC advances.
- Hit every cycle, no stall: one instruction per cycle, pc sequence P, P+4, P+8.
- Redirect with hit: target in iaddr the cycle after the redirect edge (1-cycle bubble).
- Redirect during miss: target in iaddr the cycle after the miss's ihit edge.
- Halt: iREN falls the cycle after halt is sampled.
- nRST low mid-DRAIN or mid-miss: immediate return to reset values; pending redirect lost.

## Test plan
- Reset PC_INIT=0, ihit=1 every cycle, iload=32'h2001_0001 -> iaddr 0,4,8,12 on consecutive cycles; fetch_valid=1; pc4_out=iaddr+4.
- stall=1 for 3 cycles at pc=8 with ihit=1 -> iaddr stays 8 for 3 cycles, then 12 after stall drops.
- ihit=1, redirect=1, redirect_pc=32'h100 at pc=12 -> fetch_valid=0 that cycle; next cycle iaddr=32'h100; next_pc_out=32'h100 during redirect.
- ihit=0 (miss) at pc=16, redirect to 32'h200 -> iaddr stays 16 until ihit; fetch_valid=0 on that ihit; next cycle iaddr=32'h200. Second redirect to 32'h300 during miss -> 32'h300 used.
- halt=1 coincident with redirect -> HALTED, iREN=0, halted=1, pc unchanged; stays halted 10+ cycles regardless of ihit/redirect.
- pc=32'hFFFF_FFFC, ihit=1 -> pc4_out=0, next iaddr=0; nRST pulse in DRAIN -> iaddr=PC_INIT, state RUN.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues instruction-cache reads and feeds the
// fetch/decode latch. Redirects that land during a miss wait in pend_pc until the hit.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          WORD_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              stall,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              halt,
   input  logic              ihit,
   input  logic [WORD_W-1:0] iload,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   output logic [WORD_W-1:0] fetch_instr_out,
   output logic [WORD_W-1:0] pc_out,
   output logic [WORD_W-1:0] pc4_out,
   output logic [WORD_W-1:0] next_pc_out,
   output logic              fetch_valid,
   output logic              halted,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [WORD_W-1:0] pc, pc_next;
   logic [WORD_W-1:0] pend_pc, pend_pc_next;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= RUN;
         pc      <= WORD_W'(PC_INIT);
         pend_pc <= '0;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         pend_pc <= pend_pc_next;
      end
   end

   // The PC only moves on an edge with ihit, so iaddr is stable while a read is pending.
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      pend_pc_next = pend_pc;
      if (state == HALTED) begin
         state_next = HALTED;
      end else if (halt) begin
         state_next = HALTED;
      end else begin
         case (state)
            RUN: begin
               if (redirect) begin
                  if (ihit) begin
                     pc_next = redirect_pc;
                  end else begin
                     pend_pc_next = redirect_pc;
                     state_next   = DRAIN;
                  end
               end else if (!stall && ihit) begin
                  pc_next = pc + WORD_W'(4);
               end
            end
            DRAIN: begin
               // Newest redirect wins; the outstanding word is dropped when it arrives.
               if (redirect) begin
                  pend_pc_next = redirect_pc;
                  if (ihit) begin
                     pc_next    = redirect_pc;
                     state_next = RUN;
                  end
               end else if (ihit) begin
                  pc_next    = pend_pc;
                  state_next = RUN;
               end
            end
            default: state_next = HALTED;
         endcase
      end
   end

   always_comb begin
      iaddr           = pc;
      pc_out          = pc;
      pc4_out         = pc + WORD_W'(4);
      next_pc_out     = redirect ? redirect_pc : pc4_out;
      fetch_instr_out = iload;
      iREN            = (state != HALTED);
      halted          = (state == HALTED);
      fetch_valid     = ihit && (state == RUN) && !redirect && !halt;
      fsm_state       = state;
   end

endmodule
